// File: rtl/wbuf_pkg.sv
// Shared constants and FSM encoding for the ping-pong weight buffer.
package wbuf_pkg;

    localparam logic MODE_WS = 1'b0;
    localparam logic MODE_OS = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } wbuf_state_e;

endpackage

// File: rtl/wbuf_addr_gen.sv
// Per-column read address generator: latches run parameters, steps the run
// index k and produces aligned (WS) or skewed (OS) addresses with an enable mask.
module wbuf_addr_gen
    import wbuf_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int ARRAY_M    = 8,
    parameter int LEN_WIDTH  = 9,
    parameter int NC_WIDTH   = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          load_i,
    input  logic                          run_i,
    input  logic                          mode_i,
    input  logic [ADDR_WIDTH-1:0]         base_i,
    input  logic [LEN_WIDTH-1:0]          len_i,
    input  logic [NC_WIDTH-1:0]           ncols_i,
    output logic [ARRAY_M*ADDR_WIDTH-1:0] addr_o,
    output logic [ARRAY_M-1:0]            en_o,
    output logic                          last_o
);

    localparam int CNT_W = LEN_WIDTH + 1;

    logic                  mode_q;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [LEN_WIDTH-1:0]  len_q;
    logic [NC_WIDTH-1:0]   ncols_q;
    logic [CNT_W-1:0]      k_q, k_d;
    logic [CNT_W-1:0]      rem_q, rem_d;
    logic [NC_WIDTH-1:0]   ncols_c;
    logic [CNT_W-1:0]      total_c;
    logic [CNT_W-1:0]      off;
    logic                  in_win;

    // OS runs stretch by the skew of the last active column.
    always_comb begin
        ncols_c = (ncols_i > NC_WIDTH'(ARRAY_M)) ? NC_WIDTH'(ARRAY_M) : ncols_i;
        total_c = CNT_W'(len_i);
        if (mode_i == MODE_OS && ncols_c != '0) begin
            total_c = CNT_W'(len_i) + CNT_W'(ncols_c) - CNT_W'(1);
        end
        k_d   = k_q;
        rem_d = rem_q;
        if (load_i) begin
            k_d   = '0;
            rem_d = total_c - CNT_W'(1);
        end else if (run_i) begin
            k_d   = k_q + CNT_W'(1);
            rem_d = rem_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mode_q  <= MODE_WS;
            base_q  <= '0;
            len_q   <= '0;
            ncols_q <= '0;
            k_q     <= '0;
            rem_q   <= '0;
        end else begin
            k_q   <= k_d;
            rem_q <= rem_d;
            if (load_i) begin
                mode_q  <= mode_i;
                base_q  <= base_i;
                len_q   <= len_i;
                ncols_q <= ncols_c;
            end
        end
    end

    always_comb begin
        addr_o = '0;
        en_o   = '0;
        off    = '0;
        in_win = 1'b0;
        for (int m = 0; m < ARRAY_M; m++) begin
            if (mode_q == MODE_OS) begin
                off    = k_q - CNT_W'(m);
                in_win = (k_q >= CNT_W'(m)) && (off < CNT_W'(len_q));
            end else begin
                off    = k_q;
                in_win = k_q < CNT_W'(len_q);
            end
            en_o[m] = run_i && in_win && (NC_WIDTH'(m) < ncols_q);
            addr_o[m*ADDR_WIDTH +: ADDR_WIDTH] = base_q + off[ADDR_WIDTH-1:0];
        end
    end

    assign last_o = run_i && (rem_q == '0);

endmodule

// File: rtl/wbuf_pingpong.sv
// Double-buffered weight buffer: loader fills one bank of column RAMs while
// the array streams (and optionally replays) the other.
module wbuf_pingpong
    import wbuf_pkg::*;
#(
    parameter int RAM_DEPTH  = 256,
    parameter int ADDR_WIDTH = $clog2(RAM_DEPTH),
    parameter int ARRAY_M    = 8,
    parameter int WGT_WIDTH  = 8,
    parameter int LEN_WIDTH  = ADDR_WIDTH + 1,
    parameter int NC_WIDTH   = $clog2(ARRAY_M) + 1
) (
    input  logic                         clk_i,
    input  logic                         reset_ni,
    input  logic [ARRAY_M-1:0]           wr_en_i,
    input  logic [ADDR_WIDTH-1:0]        wr_addr_i,
    input  logic [WGT_WIDTH-1:0]         wr_data_i,
    input  logic                         wr_done_i,
    output logic                         wr_ready_o,
    input  logic                         start_i,
    input  logic                         mode_i,
    input  logic [ADDR_WIDTH-1:0]        base_addr_i,
    input  logic [LEN_WIDTH-1:0]         length_i,
    input  logic [NC_WIDTH-1:0]          num_cols_i,
    input  logic                         release_i,
    output logic                         rd_bank_valid_o,
    output logic                         busy_o,
    output logic                         done_o,
    output logic [ARRAY_M-1:0]           wgt_valid_o,
    output logic [ARRAY_M*WGT_WIDTH-1:0] wgt_data_set_out_o
);

    wbuf_state_e state_q, state_d;
    logic [1:0]  full_q, full_d;
    logic        wr_ptr_q, wr_ptr_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic        release_q;
    logic        done_q;
    logic [ARRAY_M-1:0] valid_q;
    logic        start_acc;
    logic        run;
    logic        last;
    logic [ARRAY_M-1:0]            rd_en;
    logic [ARRAY_M*ADDR_WIDTH-1:0] rd_addr;
    logic [ARRAY_M*WGT_WIDTH-1:0]  bank_rdata [2];

    assign wr_ready_o      = !full_q[wr_ptr_q];
    assign rd_bank_valid_o = full_q[rd_ptr_q];
    assign start_acc       = start_i && (state_q == ST_IDLE) && rd_bank_valid_o;
    assign run             = (state_q == ST_RUN);

    wbuf_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .ARRAY_M    (ARRAY_M),
        .LEN_WIDTH  (LEN_WIDTH),
        .NC_WIDTH   (NC_WIDTH)
    ) u_addr_gen (
        .clk_i   (clk_i),
        .rst_ni  (reset_ni),
        .load_i  (start_acc),
        .run_i   (run),
        .mode_i  (mode_i),
        .base_i  (base_addr_i),
        .len_i   (length_i),
        .ncols_i (num_cols_i),
        .addr_o  (rd_addr),
        .en_o    (rd_en),
        .last_o  (last)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (start_acc) state_d = (length_i == '0) ? ST_DRAIN : ST_RUN;
            ST_RUN:   if (last) state_d = ST_DRAIN;
            ST_DRAIN: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Fill and release always target different banks, so both may land together.
    always_comb begin
        full_d   = full_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_done_i && wr_ready_o) begin
            full_d[wr_ptr_q] = 1'b1;
            wr_ptr_d         = !wr_ptr_q;
        end
        if (state_q == ST_DRAIN && release_q) begin
            full_d[rd_ptr_q] = 1'b0;
            rd_ptr_d         = !rd_ptr_q;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q   <= ST_IDLE;
            full_q    <= '0;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            release_q <= 1'b0;
            done_q    <= 1'b0;
            valid_q   <= '0;
        end else begin
            state_q  <= state_d;
            full_q   <= full_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            done_q   <= (state_q == ST_DRAIN);
            valid_q  <= rd_en;
            if (start_acc) release_q <= release_i;
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        for (genvar m = 0; m < ARRAY_M; m++) begin : g_col
            logic [WGT_WIDTH-1:0] mem [RAM_DEPTH];
            logic [WGT_WIDTH-1:0] rd_q;
            always_ff @(posedge clk_i) begin
                if (wr_en_i[m] && wr_ready_o && (wr_ptr_q == 1'(b))) begin
                    mem[wr_addr_i] <= wr_data_i;
                end
                rd_q <= mem[rd_addr[m*ADDR_WIDTH +: ADDR_WIDTH]];
            end
            assign bank_rdata[b][m*WGT_WIDTH +: WGT_WIDTH] = rd_q;
        end
    end

    // rd_ptr only moves after the last data beat, so it can steer the read mux directly.
    always_comb begin
        wgt_data_set_out_o = '0;
        for (int m = 0; m < ARRAY_M; m++) begin
            if (valid_q[m]) begin
                wgt_data_set_out_o[m*WGT_WIDTH +: WGT_WIDTH] =
                    bank_rdata[rd_ptr_q][m*WGT_WIDTH +: WGT_WIDTH];
            end
        end
    end

    assign wgt_valid_o = valid_q;
    assign done_o      = done_q;
    assign busy_o      = (state_q != ST_IDLE) || done_q;

endmodule

// File: tb/tb_wbuf_pingpong.sv
// Randomized self-checking bench for wbuf_pingpong against a bank/ownership model.
module tb_wbuf_pingpong;

    localparam int DEPTH = 256;
    localparam int AW    = 8;
    localparam int M     = 8;
    localparam int WW    = 8;
    localparam int LW    = 9;
    localparam int NCW   = 4;

    logic            clk_i = 1'b0;
    logic            reset_ni = 1'b0;
    logic [M-1:0]    wr_en_i = '0;
    logic [AW-1:0]   wr_addr_i = '0;
    logic [WW-1:0]   wr_data_i = '0;
    logic            wr_done_i = 1'b0;
    logic            wr_ready_o;
    logic            start_i = 1'b0;
    logic            mode_i = 1'b0;
    logic [AW-1:0]   base_addr_i = '0;
    logic [LW-1:0]   length_i = '0;
    logic [NCW-1:0]  num_cols_i = '0;
    logic            release_i = 1'b0;
    logic            rd_bank_valid_o;
    logic            busy_o;
    logic            done_o;
    logic [M-1:0]    wgt_valid_o;
    logic [M*WW-1:0] wgt_data_set_out_o;

    wbuf_pingpong dut (
        .clk_i              (clk_i),
        .reset_ni           (reset_ni),
        .wr_en_i            (wr_en_i),
        .wr_addr_i          (wr_addr_i),
        .wr_data_i          (wr_data_i),
        .wr_done_i          (wr_done_i),
        .wr_ready_o         (wr_ready_o),
        .start_i            (start_i),
        .mode_i             (mode_i),
        .base_addr_i        (base_addr_i),
        .length_i           (length_i),
        .num_cols_i         (num_cols_i),
        .release_i          (release_i),
        .rd_bank_valid_o    (rd_bank_valid_o),
        .busy_o             (busy_o),
        .done_o             (done_o),
        .wgt_valid_o        (wgt_valid_o),
        .wgt_data_set_out_o (wgt_data_set_out_o)
    );

    always #5 clk_i = !clk_i;

    // Reference model: bank contents and ownership.
    logic [WW-1:0] mdl_mem [2][M][DEPTH];
    bit            mdl_full [2];
    int            mdl_wr_ptr;
    int            mdl_rd_ptr;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic mdl_reset();
        mdl_full[0] = 0;
        mdl_full[1] = 0;
        mdl_wr_ptr  = 0;
        mdl_rd_ptr  = 0;
    endtask

    task automatic wr_word(input logic [M-1:0] en, input int addr, input logic [WW-1:0] data);
        wr_en_i   = en;
        wr_addr_i = AW'(addr);
        wr_data_i = data;
        if (!mdl_full[mdl_wr_ptr]) begin
            for (int m = 0; m < M; m++) if (en[m]) mdl_mem[mdl_wr_ptr][m][addr] = data;
        end
        tick();
        wr_en_i = '0;
    endtask

    task automatic wr_finish();
        wr_done_i = 1'b1;
        if (!mdl_full[mdl_wr_ptr]) begin
            mdl_full[mdl_wr_ptr] = 1;
            mdl_wr_ptr = 1 - mdl_wr_ptr;
        end
        tick();
        wr_done_i = 1'b0;
    endtask

    // pattern 0: column m, address a holds m*16+a; otherwise random
    task automatic fill_bank(input int pattern);
        for (int m = 0; m < M; m++) begin
            for (int a = 0; a < DEPTH; a++) begin
                if (pattern == 0) wr_word(M'(1 << m), a, WW'(m * 16 + a));
                else              wr_word(M'(1 << m), a, WW'($urandom));
            end
        end
        wr_finish();
    endtask

    task automatic do_run(input logic md, input int base, input int len, input int nc, input logic rel);
        int bank, ncc, issue, dn, j, addr;
        logic [M-1:0]    exp_v;
        logic [M*WW-1:0] exp_d;
        bit accepted;
        accepted    = mdl_full[mdl_rd_ptr];
        bank        = mdl_rd_ptr;
        start_i     = 1'b1;
        mode_i      = md;
        base_addr_i = AW'(base);
        length_i    = LW'(len);
        num_cols_i  = NCW'(nc);
        release_i   = rel;
        tick();
        start_i     = 1'b0;
        // scramble run inputs to confirm they were latched at start
        mode_i      = 1'($urandom);
        base_addr_i = AW'($urandom);
        length_i    = LW'($urandom);
        num_cols_i  = NCW'($urandom);
        release_i   = 1'($urandom);
        if (!accepted) begin
            for (int c = 0; c < 3; c++) begin
                chk_val("ign_busy", 64'(busy_o), 64'd0);
                chk_val("ign_valid", 64'(wgt_valid_o), 64'd0);
                tick();
            end
            return;
        end
        ncc = (nc > M) ? M : nc;
        if (len == 0)                      issue = 0;
        else if (md == 1'b1 && ncc > 0)    issue = len + ncc - 1;
        else                               issue = len;
        dn = issue + 2;
        for (int c = 1; c <= dn; c++) begin
            exp_v = '0;
            exp_d = '0;
            for (int m = 0; m < ncc; m++) begin
                j = (md == 1'b1) ? (c - 2 - m) : (c - 2);
                if (j >= 0 && j < len) begin
                    addr = (base + j) % DEPTH;
                    exp_v[m] = 1'b1;
                    exp_d[m*WW +: WW] = mdl_mem[bank][m][addr];
                end
            end
            chk_val("run_valid", 64'(wgt_valid_o), 64'(exp_v));
            chk_val("run_data", 64'(wgt_data_set_out_o), 64'(exp_d));
            chk_val("run_busy", 64'(busy_o), 64'd1);
            chk_val("run_done", 64'(done_o), 64'(c == dn));
            tick();
        end
        if (rel) begin
            mdl_full[mdl_rd_ptr] = 0;
            mdl_rd_ptr = 1 - mdl_rd_ptr;
        end
        chk_val("post_busy", 64'(busy_o), 64'd0);
        chk_val("post_done", 64'(done_o), 64'd0);
        chk_val("post_valid", 64'(wgt_valid_o), 64'd0);
        chk_val("post_rbv", 64'(rd_bank_valid_o), 64'(mdl_full[mdl_rd_ptr]));
        chk_val("post_wrdy", 64'(wr_ready_o), 64'(!mdl_full[mdl_wr_ptr]));
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk_val({tag, "_wrdy"}, 64'(wr_ready_o), 64'd1);
        chk_val({tag, "_rbv"}, 64'(rd_bank_valid_o), 64'd0);
        chk_val({tag, "_busy"}, 64'(busy_o), 64'd0);
        chk_val({tag, "_done"}, 64'(done_o), 64'd0);
        chk_val({tag, "_valid"}, 64'(wgt_valid_o), 64'd0);
        chk_val({tag, "_data"}, 64'(wgt_data_set_out_o), 64'd0);
    endtask

    initial begin
        mdl_reset();
        for (int b = 0; b < 2; b++)
            for (int m = 0; m < M; m++)
                for (int a = 0; a < DEPTH; a++) mdl_mem[b][m][a] = '0;

        #12;
        chk_idle_outputs("rst");
        @(negedge clk_i);
        reset_ni = 1'b1;
        tick();
        chk_idle_outputs("rst_rel");

        // start with no full bank is ignored
        do_run(1'b0, 0, 4, 8, 1'b1);

        // ping-pong: bank 0 pattern, WS run with release
        fill_bank(0);
        chk_val("pp_wrdy", 64'(wr_ready_o), 64'd1);
        chk_val("pp_rbv", 64'(rd_bank_valid_o), 64'd1);
        do_run(1'b0, 0, 4, 8, 1'b1);

        // bank 1: OS skew, wrap with clamp, zero length, all replayed
        fill_bank(0);
        do_run(1'b1, 0, 3, 4, 1'b0);
        do_run(1'b0, 254, 4, 12, 1'b0);
        do_run(1'b1, 254, 5, 12, 1'b0);
        do_run(1'b0, 7, 0, 8, 1'b0);

        // both banks full: writer blocked, stray write dropped
        fill_bank(1);
        chk_val("blk_wrdy", 64'(wr_ready_o), 64'd0);
        wr_word(8'hFF, 0, 8'hA5);
        wr_word(8'h01, 1, 8'h5A);
        wr_finish();
        chk_val("blk_rbv", 64'(rd_bank_valid_o), 64'd1);
        do_run(1'b0, 0, 3, 8, 1'b0);
        do_run(1'b0, 0, 3, 8, 1'b0);
        do_run(1'b1, 250, 8, 8, 1'b1);
        chk_val("blk_wrdy_after", 64'(wr_ready_o), 64'd1);
        do_run(1'b0, 0, 6, 8, 1'b1);

        // randomized runs, refilling whenever the read bank is empty
        for (int it = 0; it < 10; it++) begin
            if (!mdl_full[mdl_rd_ptr]) fill_bank(1);
            do_run(1'($urandom), int'($urandom_range(0, 255)), int'($urandom_range(0, 20)),
                   int'($urandom_range(0, 12)), 1'($urandom_range(0, 1)));
        end

        // reset in the middle of a run
        if (!mdl_full[mdl_rd_ptr]) fill_bank(1);
        start_i     = 1'b1;
        mode_i      = 1'b1;
        base_addr_i = 8'd0;
        length_i    = 9'd10;
        num_cols_i  = 4'd8;
        release_i   = 1'b1;
        tick();
        start_i = 1'b0;
        tick();
        tick();
        tick();
        chk_val("mid_busy", 64'(busy_o), 64'd1);
        reset_ni = 1'b0;
        #2;
        chk_idle_outputs("mid_rst");
        mdl_reset();
        @(negedge clk_i);
        reset_ni = 1'b1;
        tick();
        chk_idle_outputs("mid_rel");
        fill_bank(0);
        do_run(1'b0, 10, 5, 3, 1'b1);
        do_run(1'b1, 0, 2, 2, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/wbuf_pingpong.md
# wbuf_pingpong

Double-buffered weight buffer feeding the systolic array's column inputs. Two banks of ARRAY_M column RAMs let the loader fill one bank while the array streams the other. Each read run issues aligned (WS) or diagonally skewed (OS) addresses per column and zero-masks inactive columns. A bank may be replayed across runs before it is released back to the loader.

## Interface
Parameters:
- RAM_DEPTH, 256: words per column RAM per bank.
- ADDR_WIDTH, $clog2(RAM_DEPTH): word address width.
- ARRAY_M, 8: number of columns (RAMs per bank).
- WGT_WIDTH, 8: weight width.
- LEN_WIDTH, ADDR_WIDTH+1: run-length field width.

Ports:
- clk, in, 1: clock; all logic on the rising edge.
- reset, in, 1: asynchronous, active-low reset.
- wr_en, in, ARRAY_M: per-column write strobe into the fill bank.
- wr_addr, in, ADDR_WIDTH: write address.
- wr_data, in, WGT_WIDTH: write data, common to all strobed columns.
- wr_done, in, 1: pulse; marks the fill bank full.
- wr_ready, out, 1: fill bank is empty and writable.
- start, in, 1: pulse; begin a read run.
- mode, in, 1: 1 = OS (skewed), 0 = WS (aligned); sampled at start.
- base_addr, in, ADDR_WIDTH: first address of the run; sampled at start.
- length, in, LEN_WIDTH: words per column; sampled at start.
- num_cols, in, $clog2(ARRAY_M)+1: active columns; values above ARRAY_M clamp to ARRAY_M; sampled at start.
- release, in, 1: sampled at start; if 1, the bank is freed at run end.
- rd_bank_valid, out, 1: read bank is full.
- busy, out, 1: a run is in progress.
- done, out, 1: one-cycle pulse at run end.
- wgt_valid, out, ARRAY_M: per-column data-valid.
- wgt_data_set_out, out, ARRAY_M*WGT_WIDTH: column m occupies bits [m*WGT_WIDTH +: WGT_WIDTH].

## Operation
- State: full[1:0], wr_ptr, rd_ptr. Reset clears all of them to 0.
- Write side:
  - Writes go to bank wr_ptr, and only while wr_ready = !full[wr_ptr]. Writes while wr_ready=0 are dropped.
  - wr_done with wr_ready=1 sets full[wr_ptr] and toggles wr_ptr. wr_done with wr_ready=0 is ignored.
- Read side:
  - rd_bank_valid = full[rd_ptr].
  - start is accepted only in IDLE with rd_bank_valid=1; otherwise it is ignored.
- FSM states: IDLE, RUN, DRAIN.
  - IDLE -> RUN on an accepted start with length>0.
  - An accepted start with length=0 goes IDLE -> DRAIN directly; no column goes valid.
  - RUN -> DRAIN after the last address issue cycle.
  - DRAIN -> IDLE after one cycle. done is asserted in DRAIN.
  - In DRAIN, if release was latched, clear full[rd_ptr] and toggle rd_ptr.
- Address issue, with k = RUN cycle index from 0:
  - WS: column m reads base_addr+k for k in 0..length-1. Run lasts length cycles.
  - OS: column m reads base_addr+(k-m) for k in m..m+length-1. Run lasts length+num_cols-1 cycles (length cycles if num_cols=0).
  - Columns m >= num_cols are never enabled.
- Address arithmetic is modulo RAM_DEPTH (wraps).
- Output: a column that is not enabled outputs 0 with wgt_valid[m]=0.
- Simultaneous events:
  - wr_done and a release land on different banks by construction; both take effect in the same cycle.
  - When a release frees the bank the writer is blocked on, wr_ready rises the next cycle.
  - wr_done and start in the same cycle: start evaluates rd_bank_valid from the pre-edge state.
- Reset mid-run: returns to IDLE and clears the full flags, pointers and outputs. RAM contents are not cleared.

## Timing
- RAM read is synchronous, 1-cycle latency. Address issued in cycle t gives data and wgt_valid in cycle t+1; the enable mask is pipelined to match.
- start accepted at edge 0: first address in cycle 1, first wgt_valid in cycle 2.
- done asserts in the cycle after the last valid data. busy is high from the cycle after an accepted start through the done cycle.
- Reset values: wr_ready=1, rd_bank_valid=0, busy=0, done=0, wgt_valid=0, wgt_data_set_out=0.
- Write takes effect at the edge; same-bank read-after-write is not possible (ownership is exclusive).

## Structure
- Package wbuf_pkg:
  - MODE_WS=1'b0, MODE_OS=1'b1.
  - FSM state encoding (IDLE, RUN, DRAIN).
- Sub-module wbuf_addr_gen: latches the run parameters, counts k, and outputs ARRAY_M addresses plus the enable mask and last_issue.
- Top level: two generate-arrays of ram (bank 0/1), bank steering by wr_ptr/rd_ptr, full flags, FSM, output mask.

## Test plan
- Ping-pong:
  - Fill bank 0 with column m, addr a = m*16+a, then wr_done.
  - wr_ready stays 1 (bank 1 empty), rd_bank_valid=1.
  - WS run, base 0, length 4, num_cols 8, release 1: cycles 2..5 show column m = m*16+0..3.
  - done in cycle 6; rd_bank_valid=0.
- OS skew: same data, length 3, num_cols 4.
  - Column m is valid in cycles 2+m..4+m.
  - Columns 4..7 are always 0 and invalid.
  - Run lasts 6 issue cycles.
- Replay and blocking:
  - Fill both banks; wr_ready=0, and a further write is dropped.
  - Run with release=0: bank stays full. A second run returns identical data.
  - Run with release=1: wr_ready rises the cycle after done.
- Wrap: RAM_DEPTH=256, base 254, length 4 reads addresses 254, 255, 0, 1.
- Edges:
  - start with rd_bank_valid=0 is ignored (busy stays 0).
  - length=0 gives done 2 cycles after start with no valid.
  - num_cols=12 clamps to 8.
- Reset mid-run: assert reset in RUN. All outputs go 0 immediately and wr_ready=1. After release of reset, a new fill and run works.
